// File: rtl/debug_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : debug_pkg
//  Purpose  : Shared types and helpers for the debug-module memory responder.
//  Revision : 1.0  initial release
// ============================================================================
package debug_pkg;

  typedef enum logic [1:0] {
    DM_MEM_IDLE = 2'd0,
    DM_MEM_REQ  = 2'd1,
    DM_MEM_RESP = 2'd2,
    DM_MEM_DONE = 2'd3
  } dm_mem_state_e;

  localparam int unsigned DM_MEM_TMO_DEFAULT = 256;

  // Only naturally aligned byte, halfword and word accesses may reach the bus
  function automatic logic legal_strobe(input logic [3:0] st);
    logic ok;
    case (st)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm_mem_timeout.sv
`default_nettype none
// ============================================================================
//  Module   : dm_mem_timeout
//  Purpose  : Per-phase watchdog counter. load_i clears the count, en_i lets
//             it run; expired_o flags the TMO_CYC-th enabled cycle.
//  Revision : 1.0  initial release
// ============================================================================
module dm_mem_timeout #(
  parameter int unsigned TMO_CYC = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TMO_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = en_i && (cnt_q == CNT_LAST);

  // Next count: restart on phase entry, otherwise advance while the phase runs
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dm_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dm_mem_responder
//  Purpose  : Runs one DM abstract memory request as a single req/gnt/rvalid
//             bus transaction and returns data with a one-cycle done pulse.
//             Optional macro DBG_MEM_TIMEOUT_EN adds a per-phase timeout.
//  Revision : 1.0  initial release
// ============================================================================
module dm_mem_responder
  import debug_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TMO_CYC = DM_MEM_TMO_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          am_en_i,
  input  logic          am_wr_i,
  input  logic [3:0]    am_st_i,
  input  logic [AW-1:0] am_ad_i,
  input  logic [DW-1:0] am_di_i,
  output logic [DW-1:0] am_do_o,
  output logic          am_done_o,
  output logic          am_err_o,
  output logic          bus_req_o,
  output logic          bus_we_o,
  output logic [3:0]    bus_be_o,
  output logic [AW-1:0] bus_addr_o,
  output logic [DW-1:0] bus_wdata_o,
  input  logic          bus_gnt_i,
  input  logic          bus_rvalid_i,
  input  logic [DW-1:0] bus_rdata_i,
  input  logic          bus_err_i
);

  dm_mem_state_e state_q, state_d;
  logic          am_en_q;
  logic          wr_q, wr_d;
  logic [3:0]    be_q, be_d;
  logic [AW-3:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] do_q, do_d;
  logic          err_q, err_d;
  logic          skip_q, skip_d;
  logic          tmo_expired;
  logic          accept;
  logic          rsp_valid;
  logic [DW-1:0] lane_mask;

  // A held enable must fall before it can start another transaction
  assign accept    = (state_q == DM_MEM_IDLE) && am_en_i && !am_en_q;
  // A response owed to a timed-out transaction is swallowed, not consumed
  assign rsp_valid = bus_rvalid_i && !skip_q;

`ifdef DBG_MEM_TIMEOUT_EN
  logic tmo_load;
  logic tmo_run;

  assign tmo_run  = (state_q == DM_MEM_REQ) || (state_q == DM_MEM_RESP);
  assign tmo_load = (state_d != state_q);

  dm_mem_timeout #(
    .TMO_CYC (TMO_CYC)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (tmo_load),
    .en_i      (tmo_run),
    .expired_o (tmo_expired)
  );

  // One-deep flag marking that a late response is still in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      skip_q <= 1'b0;
    end else begin
      skip_q <= skip_d;
    end
  end
`else
  logic unused_tmo;

  assign tmo_expired = 1'b0;
  assign skip_q      = 1'b0;
  assign unused_tmo  = ^{TMO_CYC, skip_d};
`endif

  // Byte-lane mask of the latched strobes; unrequested read lanes return zero
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < 4; i++) begin
      lane_mask[8*i +: 8] = {8{be_q[i]}};
    end
  end

  // Transaction sequencing and result capture
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    do_d    = do_q;
    err_d   = err_q;
    skip_d  = skip_q && !bus_rvalid_i;
    case (state_q)
      DM_MEM_IDLE: begin
        if (accept) begin
          wr_d    = am_wr_i;
          be_d    = am_st_i;
          addr_d  = am_ad_i[AW-1:2];
          wdata_d = am_di_i;
          if (legal_strobe(am_st_i)) begin
            err_d   = 1'b0;
            state_d = DM_MEM_REQ;
          end else begin
            err_d   = 1'b1;
            state_d = DM_MEM_DONE;
          end
        end
      end
      DM_MEM_REQ: begin
        // A grant always wins: once accepted the bus owes us a response
        if (bus_gnt_i) begin
          state_d = DM_MEM_RESP;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = DM_MEM_DONE;
        end
      end
      DM_MEM_RESP: begin
        if (rsp_valid) begin
          if (!wr_q) begin
            do_d = bus_rdata_i & lane_mask;
          end
          err_d   = bus_err_i;
          state_d = DM_MEM_DONE;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          skip_d  = 1'b1;
          state_d = DM_MEM_DONE;
        end
      end
      DM_MEM_DONE: begin
        state_d = DM_MEM_IDLE;
      end
      default: begin
        state_d = DM_MEM_IDLE;
      end
    endcase
  end

  // State, request and result registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= DM_MEM_IDLE;
      am_en_q <= 1'b0;
      wr_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      do_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      am_en_q <= am_en_i;
      wr_q    <= wr_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      do_q    <= do_d;
      err_q   <= err_d;
    end
  end

  assign bus_req_o   = (state_q == DM_MEM_REQ);
  assign bus_we_o    = wr_q;
  assign bus_be_o    = be_q;
  assign bus_addr_o  = {addr_q, 2'b00};
  assign bus_wdata_o = wdata_q;
  assign am_do_o     = do_q;
  assign am_err_o    = err_q;
  assign am_done_o   = (state_q == DM_MEM_DONE);

endmodule
`default_nettype wire

// File: tb/tb_dm_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dm_mem_responder
//  Purpose  : Scoreboard bench for dm_mem_responder: directed cases plus
//             random traffic against a word-memory reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dm_mem_responder;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef DBG_MEM_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 256;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          am_en = 1'b0, am_wr = 1'b0;
  logic [3:0]    am_st = '0;
  logic [AW-1:0] am_ad = '0;
  logic [DW-1:0] am_di = '0;
  logic [DW-1:0] am_do;
  logic          am_done, am_err;
  logic          bus_req, bus_we;
  logic [3:0]    bus_be;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_gnt = 1'b0, bus_rvalid = 1'b0, bus_err = 1'b0;
  logic [DW-1:0] bus_rdata = '0;

  dm_mem_responder #(.AW(AW), .DW(DW), .TMO_CYC(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .am_en_i(am_en), .am_wr_i(am_wr), .am_st_i(am_st), .am_ad_i(am_ad), .am_di_i(am_di),
    .am_do_o(am_do), .am_done_o(am_done), .am_err_o(am_err),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_be_o(bus_be), .bus_addr_o(bus_addr),
    .bus_wdata_o(bus_wdata), .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid),
    .bus_rdata_i(bus_rdata), .bus_err_i(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gdly;
    int          rdly;
    logic        err;
    bit          hang;
    bit          nogo;
  } plan_t;

  exp_t        exp_q[$];
  plan_t       plan_q[$];
  logic [31:0] slv_mem [16];
  logic [31:0] ref_mem [16];
  logic [31:0] last_do = '0;
  logic [3:0]  legal_tab [7];
  int          errors = 0;
  int          checks = 0;
  int          n_done = 0;
  int          last_req_cycles = 0;
  bit          stray = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    errors++;
    $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] st);
    logic [31:0] m;
    m = '0;
    for (int l = 0; l < 4; l++) if (st[l]) m = m | (32'hFF << (8 * l));
    return m;
  endfunction

  function automatic bit strobe_ok(input logic [3:0] st);
    return st inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
  endfunction

  // Monitor: every done pulse consumes exactly one expected result
  initial begin : monitor
    bit   prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (am_done) begin
          n_done++;
          chk("done_single_cycle", prev, 1'b0);
          if (exp_q.size() == 0) begin
            fail("unexpected_done", am_err, 0);
          end else begin
            e = exp_q.pop_front();
            chk("am_do", am_do, e.d);
            chk("am_err", am_err, e.e);
          end
        end
        prev = am_done;
      end
    end
  end

  // Bus slave: serves planned transactions and checks the request side
  initial begin : slave
    plan_t        p;
    int           n;
    logic [127:0] snap;
    forever begin
      @(negedge clk);
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
      if (stray) begin
        bus_rvalid = 1'b1; bus_rdata = 32'hBAD0_BAD0; stray = 1'b0;
      end else if (!rst && bus_req) begin
        if (plan_q.size() == 0) begin
          fail("unexpected_bus_req", bus_addr, 0);
          for (int k = 0; k < 300 && bus_req; k++) @(negedge clk);
        end else begin
          p = plan_q.pop_front();
          chk("bus_addr", bus_addr, {p.addr[31:2], 2'b00});
          chk("bus_be", bus_be, p.be);
          chk("bus_we", bus_we, p.we);
          chk("bus_wdata", bus_wdata, p.wdata);
          snap = {bus_we, bus_be, bus_addr, bus_wdata};
          n = 1;
          for (int i = 0; i < p.gdly && bus_req && !rst; i++) begin
            @(negedge clk);
            if (bus_req) begin
              n++;
              chk("req_stable", {bus_we, bus_be, bus_addr, bus_wdata}, snap);
            end
          end
          last_req_cycles = n;
          if (p.nogo) begin
            chk("req_dropped_on_tmo", bus_req, 1'b0);
          end else if (!bus_req) begin
            fail("req_withdrawn", n, p.gdly + 1);
          end else begin
            bus_gnt = 1'b1;
            @(negedge clk);
            bus_gnt = 1'b0;
            chk("req_low_after_gnt", bus_req, 1'b0);
            if (!p.hang) begin
              repeat (p.rdly) @(negedge clk);
              bus_rvalid = 1'b1;
              bus_err    = p.err;
              bus_rdata  = slv_mem[p.addr[5:2]];
              if (p.we && !p.err)
                slv_mem[p.addr[5:2]] = (slv_mem[p.addr[5:2]] & ~lane_mask(p.be)) |
                                       (p.wdata & lane_mask(p.be));
            end
          end
        end
      end
    end
  end

  // Stimulus: predicts the result, plans the bus side, runs one request
  task automatic issue(input bit wr, input logic [3:0] st, input logic [31:0] ad,
                       input logic [31:0] di, input int gd, input int rd, input bit er,
                       input bit nogo, input bit rtmo, input bit hold, output int lat);
    plan_t       p;
    exp_t        e;
    logic [31:0] m;
    int          idx;
    idx = int'(ad[5:2]);
    m   = lane_mask(st);
    if (!strobe_ok(st)) begin
      e.d = last_do; e.e = 1'b1;
    end else begin
      p.we = wr; p.be = st; p.addr = ad; p.wdata = di; p.err = er;
      p.gdly = nogo ? 4 * TMO : gd;
      p.rdly = rtmo ? TMO + 6 : rd;
      p.hang = 1'b0; p.nogo = nogo;
      plan_q.push_back(p);
      if (nogo || rtmo) begin
        e.d = last_do; e.e = 1'b1;
      end else if (wr) begin
        if (!er) ref_mem[idx] = (ref_mem[idx] & ~m) | (di & m);
        e.d = last_do; e.e = er;
      end else begin
        last_do = ref_mem[idx] & m;
        e.d = last_do; e.e = er;
      end
    end
    exp_q.push_back(e);
    am_wr = wr; am_st = st; am_ad = ad; am_di = di; am_en = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!am_done && lat < 400);
    if (!am_done) fail("done_timeout", lat, 0);
    if (!hold) am_en = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "bench watchdog expired");
  end

  initial begin : stimulus
    int          lat;
    int          reqs;
    int          n0;
    plan_t       p;
    legal_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    for (int i = 0; i < 16; i++) begin
      slv_mem[i] = (32'h1111_1111 * i) ^ 32'h5A5A_0F0F;
      ref_mem[i] = slv_mem[i];
    end
    slv_mem[1] = 32'hDEAD_BEEF;
    ref_mem[1] = 32'hDEAD_BEEF;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_am_done", am_done, 0);
    chk("rst_am_err", am_err, 0);
    chk("rst_am_do", am_do, 0);
    chk("rst_bus_fields", {bus_we, bus_be, bus_addr, bus_wdata}, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: full-word read, zero-wait bus
    issue(0, 4'b1111, 32'h8000_0004, 32'h0, 0, 0, 0, 0, 0, 0, lat);
    chk("t1_latency", lat, 3);
    @(negedge clk);

    // 2: upper-halfword write with a slow grant
    issue(1, 4'b1100, 32'h0000_0002, 32'hABCD_0000, 5, 0, 0, 0, 0, 0, lat);
    chk("t2_req_cycles", last_req_cycles, 6);
    @(negedge clk);

    // 3: illegal strobe finishes with an error and no bus traffic
    issue(0, 4'b0101, 32'h8000_0008, 32'h0, 0, 0, 0, 0, 0, 0, lat);
    chk("t3_illegal_latency", (lat <= 2), 1'b1);
    @(negedge clk);

    // 4: bus error on read, enable held afterwards must not replay
    issue(0, 4'b0011, 32'h8000_000C, 32'h0, 1, 2, 1, 0, 0, 1, lat);
    reqs = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus_req) reqs++;
    end
    chk("t4_held_en_no_replay", reqs, 0);
    am_en = 1'b0;
    @(negedge clk);

    // 5: reset while waiting for the response
    p.we = 0; p.be = 4'hF; p.addr = 32'h8000_0008; p.wdata = '0;
    p.gdly = 0; p.rdly = 0; p.err = 0; p.hang = 1; p.nogo = 0;
    plan_q.push_back(p);
    am_wr = 0; am_st = 4'hF; am_ad = 32'h8000_0008; am_di = '0; am_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_no_done_in_resp", am_done, 0);
    rst = 1'b1; am_en = 1'b0;
    #1;
    chk("t5_rst_outputs", {bus_req, am_done, am_err, am_do}, 0);
    @(negedge clk);
    rst = 1'b0;
    last_do = '0;
    n0 = n_done;
    stray = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5_stray_rvalid_ignored", n_done - n0, 0);
    chk("t5_no_req_after_stray", bus_req, 0);
    issue(0, 4'b1111, 32'h8000_0004, 32'h0, 0, 1, 0, 0, 0, 0, lat);
    @(negedge clk);

`ifdef DBG_MEM_TIMEOUT_EN
    // 6: grant never comes, then a response that arrives too late
    issue(0, 4'b1111, 32'h8000_0010, 32'h0, 0, 0, 0, 1, 0, 0, lat);
    repeat (2) @(negedge clk);
    chk("t6_req_tmo_cycles", last_req_cycles, TMO);
    issue(0, 4'b1111, 32'h8000_0014, 32'h0, 0, 0, 0, 0, 1, 0, lat);
    @(negedge clk);
    issue(0, 4'b0011, 32'h8000_0004, 32'h0, 0, 0, 0, 0, 0, 0, lat);
    @(negedge clk);
`endif

    // Random traffic
    for (int t = 0; t < 40; t++) begin
      logic [3:0]  st;
      logic [31:0] ad;
      st = ($urandom_range(0, 9) < 7) ? legal_tab[$urandom_range(0, 6)] : 4'($urandom_range(0, 15));
      ad = 32'h8000_0000 | 32'($urandom_range(0, 63));
      issue(1'($urandom_range(0, 1)), st, ad, $urandom, $urandom_range(0, 3),
            $urandom_range(0, 3), ($urandom_range(0, 7) == 0), 0, 0, 0, lat);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("exp_queue_drained", exp_q.size(), 0);
    chk("plan_queue_drained", plan_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
